// File: rtl/pc_update_unit.sv
// Program-counter stage: next-PC selection, PC register, misaligned-jr trap FSM.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic [1:0]  PCSource,
  input  logic        LineSelection,
  input  logic [15:0] Imm16,
  input  logic [25:0] JumpAddr,
  input  logic [31:0] RegA,
  input  logic        Resume,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Trap,
  output logic [31:0] EPC,
  output logic [31:0] BadAddr,
  output logic [15:0] BranchCount,
  output logic [15:0] TakenCount
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t      state_r;
  state_t      stateNext_s;
  logic [31:0] pc_r;
  logic [31:0] pcNext_s;
  logic [31:0] epc_r;
  logic [31:0] epcNext_s;
  logic [31:0] badAddr_r;
  logic [31:0] badAddrNext_s;
  logic        trap_r;
  logic [31:0] pcPlus4_s;
  logic [31:0] branchOff_s;
  logic [31:0] target_s;

  assign pcPlus4_s   = pc_r + 32'd4;
  assign branchOff_s = {{14{Imm16[15]}}, Imm16, 2'b00};

  // Target address for the selected PC source
  always_comb begin
    target_s = pcPlus4_s;
    case (PCSource)
      2'b00: target_s = pcPlus4_s;
      2'b01: begin
        if (LineSelection) begin
          target_s = pcPlus4_s + branchOff_s;
        end else begin
          target_s = pcPlus4_s;
        end
      end
      2'b10:   target_s = {pcPlus4_s[31:28], JumpAddr, 2'b00};
      2'b11:   target_s = RegA;
      default: target_s = pcPlus4_s;
    endcase
  end

  // Next-state and next-register values of the RUN/TRAP machine
  always_comb begin
    stateNext_s   = state_r;
    pcNext_s      = pc_r;
    epcNext_s     = epc_r;
    badAddrNext_s = badAddr_r;
    case (state_r)
      RUN: begin
        if (PCWrite) begin
          // Only jr can produce a misaligned target; PC holds on the fault.
          if ((PCSource == 2'b11) && (RegA[1:0] != 2'b00)) begin
            epcNext_s     = pc_r;
            badAddrNext_s = RegA;
            stateNext_s   = TRAP;
          end else begin
            pcNext_s = target_s;
          end
        end else begin
          pcNext_s = pc_r;
        end
      end
      TRAP: begin
        if (Resume) begin
          pcNext_s    = TRAP_VECTOR;
          stateNext_s = RUN;
        end else begin
          stateNext_s = TRAP;
        end
      end
      default: stateNext_s = RUN;
    endcase
  end

  // PC, trap state and fault capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= RUN;
      pc_r      <= RESET_PC;
      epc_r     <= 32'h0000_0000;
      badAddr_r <= 32'h0000_0000;
      trap_r    <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      pc_r      <= pcNext_s;
      epc_r     <= epcNext_s;
      badAddr_r <= badAddrNext_s;
      trap_r    <= (stateNext_s == TRAP);
    end
  end

  assign PC      = pc_r;
  assign PCPlus4 = pcPlus4_s;
  assign Trap    = trap_r;
  assign EPC     = epc_r;
  assign BadAddr = badAddr_r;

`ifdef BRANCH_STATS_EN
  logic [15:0] branchCount_r;
  logic [15:0] takenCount_r;
  logic        branchCommit_s;

  assign branchCommit_s = (state_r == RUN) && PCWrite && (PCSource == 2'b01);

  // Saturating branch / taken-branch counters
  always_ff @(posedge clk) begin
    if (reset) begin
      branchCount_r <= 16'h0000;
      takenCount_r  <= 16'h0000;
    end else begin
      if (branchCommit_s && (branchCount_r != 16'hFFFF)) begin
        branchCount_r <= branchCount_r + 16'd1;
      end
      if (branchCommit_s && LineSelection && (takenCount_r != 16'hFFFF)) begin
        takenCount_r <= takenCount_r + 16'd1;
      end
    end
  end

  assign BranchCount = branchCount_r;
  assign TakenCount  = takenCount_r;
`else
  assign BranchCount = 16'h0000;
  assign TakenCount  = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Table-driven, scoreboarded bench for pc_update_unit (both BRANCH_STATS_EN builds).
module tb_pc_update_unit;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [1:0]  src;
    logic        ls;
    logic [15:0] imm;
    logic [25:0] ja;
    logic [31:0] ra;
    logic        res;
    logic [31:0] ePc;
    logic        eTrap;
    logic [31:0] eEpc;
    logic [31:0] eBad;
    logic [15:0] eBr;
    logic [15:0] eTk;
  } vec_t;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, PCWrite, LineSelection, Resume;
  logic [1:0]  PCSource;
  logic [15:0] Imm16;
  logic [25:0] JumpAddr;
  logic [31:0] RegA;
  logic [31:0] PC, PCPlus4, EPC, BadAddr;
  logic        Trap;
  logic [15:0] BranchCount, TakenCount;

  int total = 0;
  int bad   = 0;
  vec_t sbQ[$];
  vec_t vecs[22];

  pc_update_unit dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCSource(PCSource),
    .LineSelection(LineSelection), .Imm16(Imm16), .JumpAddr(JumpAddr),
    .RegA(RegA), .Resume(Resume), .PC(PC), .PCPlus4(PCPlus4), .Trap(Trap),
    .EPC(EPC), .BadAddr(BadAddr), .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic wr, logic [1:0] src, logic ls,
                              logic [15:0] imm, logic [25:0] ja, logic [31:0] ra,
                              logic res, logic [31:0] ePc, logic eTrap,
                              logic [31:0] eEpc, logic [31:0] eBad,
                              logic [15:0] eBr, logic [15:0] eTk);
    vec_t v;
    v.rst = rst; v.wr = wr; v.src = src; v.ls = ls; v.imm = imm; v.ja = ja;
    v.ra = ra; v.res = res; v.ePc = ePc; v.eTrap = eTrap; v.eEpc = eEpc;
    v.eBad = eBad; v.eBr = eBr; v.eTk = eTk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset = v.rst; PCWrite = v.wr; PCSource = v.src; LineSelection = v.ls;
    Imm16 = v.imm; JumpAddr = v.ja; RegA = v.ra; Resume = v.res;
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic applyVec(input vec_t v, input int idx);
    vec_t e;
    drive(v);
    sbQ.push_back(v);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty vec=%0d", idx);
    end else begin
      e = sbQ.pop_front();
      check($sformatf("pc[%0d]", idx), PC, e.ePc);
      check($sformatf("pcplus4[%0d]", idx), PCPlus4, e.ePc + 32'd4);
      check($sformatf("trap[%0d]", idx), {31'd0, Trap}, {31'd0, e.eTrap});
      check($sformatf("epc[%0d]", idx), EPC, e.eEpc);
      check($sformatf("badaddr[%0d]", idx), BadAddr, e.eBad);
      check($sformatf("brcount[%0d]", idx), {16'd0, BranchCount}, {16'd0, (STATS ? e.eBr : 16'h0000)});
      check($sformatf("tkcount[%0d]", idx), {16'd0, TakenCount}, {16'd0, (STATS ? e.eTk : 16'h0000)});
    end
  endtask

  initial begin
    vec_t v;
    //               rst  wr   src    ls   imm       ja          ra            res  ePc           eTrap eEpc      eBad           eBr eTk
    vecs[0]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,      32'h0,        1'b0, 32'h0000_0000, 1'b0, 32'h0,     32'h0,         16'd0, 16'd0);
    vecs[1]  = mk(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 26'h0,      32'h0,        1'b0, 32'h0000_0004, 1'b0, 32'h0,     32'h0,         16'd0, 16'd0);
    vecs[2]  = mk(1'b0, 1'b1, 2'b00, 1'b1, 16'h0000, 26'h0,      32'h0,        1'b0, 32'h0000_0008, 1'b0, 32'h0,     32'h0,         16'd0, 16'd0);
    vecs[3]  = mk(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 26'h0,      32'h0,        1'b0, 32'h0000_000C, 1'b0, 32'h0,     32'h0,         16'd0, 16'd0);
    vecs[4]  = mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 26'h0,      32'h100,      1'b0, 32'h0000_0100, 1'b0, 32'h0,     32'h0,         16'd0, 16'd0);
    vecs[5]  = mk(1'b0, 1'b1, 2'b01, 1'b1, 16'hFFFE, 26'h0,      32'h0,        1'b0, 32'h0000_00FC, 1'b0, 32'h0,     32'h0,         16'd1, 16'd1);
    vecs[6]  = mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 26'h0,      32'h100,      1'b0, 32'h0000_0100, 1'b0, 32'h0,     32'h0,         16'd1, 16'd1);
    vecs[7]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 16'hFFFE, 26'h0,      32'h0,        1'b0, 32'h0000_0104, 1'b0, 32'h0,     32'h0,         16'd2, 16'd1);
    vecs[8]  = mk(1'b0, 1'b1, 2'b11, 1'b1, 16'h0000, 26'h0,      32'h1000_0010,1'b0, 32'h1000_0010, 1'b0, 32'h0,     32'h0,         16'd2, 16'd1);
    vecs[9]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 16'h0000, 26'h40,     32'h0,        1'b0, 32'h1000_0100, 1'b0, 32'h0,     32'h0,         16'd2, 16'd1);
    vecs[10] = mk(1'b0, 1'b0, 2'b01, 1'b1, 16'h0010, 26'h0,      32'h0,        1'b0, 32'h1000_0100, 1'b0, 32'h0,     32'h0,         16'd2, 16'd1);
    vecs[11] = mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 26'h0,      32'h200,      1'b0, 32'h0000_0200, 1'b0, 32'h0,     32'h0,         16'd2, 16'd1);
    vecs[12] = mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 26'h0,      32'h302,      1'b0, 32'h0000_0200, 1'b1, 32'h200,   32'h302,       16'd2, 16'd1);
    vecs[13] = mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0004, 26'h0,      32'h0,        1'b0, 32'h0000_0200, 1'b1, 32'h200,   32'h302,       16'd2, 16'd1);
    vecs[14] = mk(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 26'h0,      32'h0,        1'b1, 32'h0000_0080, 1'b0, 32'h200,   32'h302,       16'd2, 16'd1);
    vecs[15] = mk(1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,      32'h0,        1'b1, 32'h0000_0080, 1'b0, 32'h200,   32'h302,       16'd2, 16'd1);
    vecs[16] = mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 26'h0,      32'h1,        1'b0, 32'h0000_0080, 1'b1, 32'h80,    32'h1,         16'd2, 16'd1);
    vecs[17] = mk(1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 26'h0,      32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0,     32'h0,         16'd0, 16'd0);
    vecs[18] = mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 26'h0,      32'hFFFF_FFFC,1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0,     32'h0,         16'd0, 16'd0);
    vecs[19] = mk(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 26'h0,      32'h0,        1'b0, 32'h0000_0000, 1'b0, 32'h0,     32'h0,         16'd0, 16'd0);
    vecs[20] = mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0003, 26'h0,      32'h0,        1'b0, 32'h0000_0010, 1'b0, 32'h0,     32'h0,         16'd1, 16'd1);
    vecs[21] = mk(1'b0, 1'b1, 2'b10, 1'b1, 16'hFFFF, 26'h3FFFFFF,32'h0,        1'b0, 32'h0FFF_FFFC, 1'b0, 32'h0,     32'h0,         16'd1, 16'd1);

    reset = 1'b1; PCWrite = 1'b0; PCSource = 2'b00; LineSelection = 1'b0;
    Imm16 = 16'h0; JumpAddr = 26'h0; RegA = 32'h0; Resume = 1'b0;

    for (int i = 0; i < 22; i++) begin
      applyVec(vecs[i], i);
    end

    // Five branches, three taken, then a branch strobe while trapped (not counted).
    applyVec(mk(1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0, 16'd0, 16'd0), 100);
    applyVec(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0, 26'h0, 32'h0, 1'b0, 32'h4,  1'b0, 32'h0, 32'h0, 16'd1, 16'd1), 101);
    applyVec(mk(1'b0, 1'b1, 2'b01, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h8,  1'b0, 32'h0, 32'h0, 16'd2, 16'd1), 102);
    applyVec(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0, 26'h0, 32'h0, 1'b0, 32'hC,  1'b0, 32'h0, 32'h0, 16'd3, 16'd2), 103);
    applyVec(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0, 26'h0, 32'h0, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0, 16'd4, 16'd3), 104);
    applyVec(mk(1'b0, 1'b1, 2'b01, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h14, 1'b0, 32'h0, 32'h0, 16'd5, 16'd3), 105);
    applyVec(mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h2, 1'b0, 32'h14, 1'b1, 32'h14, 32'h2, 16'd5, 16'd3), 106);
    applyVec(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0, 26'h0, 32'h0, 1'b0, 32'h14, 1'b1, 32'h14, 32'h2, 16'd5, 16'd3), 107);

    // Saturation: 65535 taken branches from reset, then one more must stay at FFFF.
    applyVec(mk(1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'd0, 16'd0), 200);
    v = mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'd0, 16'd0);
    for (int n = 0; n < 65535; n++) begin
      drive(v);
      @(posedge clk);
    end
    applyVec(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0004_0000, 1'b0, 32'h0, 32'h0, 16'hFFFF, 16'hFFFF), 201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Program-counter stage that consumes LineSelection from the branch-decision logic and the control unit's PC-write strobe. It computes the next PC (sequential, conditional branch, jump, register jump) and holds it in the PC register feeding instruction fetch. It also traps misaligned register-jump targets and stays in trap until software resumes it. Optional branch statistics counters are included.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0080, PC value loaded on Resume from trap
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- PCWrite  input  1  one-cycle strobe from control unit: commit next PC
- PCSource  input  2  00 sequential, 01 conditional branch, 10 jump, 11 register jump (jr)
- LineSelection  input  1  branch-taken decision from branch-decision logic
- Imm16  input  16  branch offset, in words, signed
- JumpAddr  input  26  jump target field
- RegA  input  32  register-jump target
- Resume  input  1  leave trap state
- PC  output  32  current program counter
- PCPlus4  output  32  PC + 4, combinational from PC
- Trap  output  1  high while in TRAP state
- EPC  output  32  PC of the faulting jr
- BadAddr  output  32  faulting target address
- BranchCount  output  16  conditional branches committed (see Configuration)
- TakenCount  output  16  conditional branches taken (see Configuration)

## Operation
- FSM states: RUN, TRAP. Reset state is RUN.
- Next-PC selection, evaluated combinationally:
  - 00: PCPlus4.
  - 01: if LineSelection is 1, PCPlus4 + (sign-extended Imm16 << 2); otherwise PCPlus4.
  - 10: {PCPlus4[31:28], JumpAddr, 2'b00}.
  - 11: RegA.
- Jump and jr are unconditional. LineSelection is ignored for PCSource 10 and 11.
- All additions are 32-bit modulo 2^32. Wrap-around is silent.
- RUN with PCWrite=1:
  - PCSource=11 and RegA[1:0]≠0: PC holds. EPC←PC, BadAddr←RegA, state→TRAP.
  - Otherwise: PC←next PC.
- RUN with PCWrite=0: PC holds.
- TRAP: PCWrite is ignored and PC holds. Resume=1 loads PC←TRAP_VECTOR and state→RUN. EPC and BadAddr hold until the next trap.
- Resume in RUN is ignored. PCWrite and Resume together in TRAP: Resume wins, PCWrite is discarded.
- Branch and jump targets are always word-aligned by construction. Only jr can trap.

## Timing
- Reset values: PC=RESET_PC, PCPlus4=RESET_PC+4, Trap=0, EPC=0, BadAddr=0, BranchCount=0, TakenCount=0, state RUN.
- Reset has priority over all inputs, including mid-trap and concurrent PCWrite.
- Latency: PC updates on the rising edge where PCWrite=1. New PC and PCPlus4 are visible the same cycle after that edge.
- Trap asserts on the edge that samples the faulting PCWrite. It deasserts on the edge that samples Resume.
- Inputs PCSource, LineSelection, Imm16, JumpAddr and RegA need only be valid in the PCWrite cycle.

## Configuration
- BRANCH_STATS_EN defined:
  - BranchCount increments on each committed PCWrite with PCSource=01 in RUN.
  - TakenCount increments when such a write also has LineSelection=1.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- BRANCH_STATS_EN undefined: no counter flops. BranchCount and TakenCount are tied to 0.

## Test plan
- Reset, then PCWrite with PCSource=00 three times -> PC = 0, 4, 8, 12.
- PC=0x100, PCSource=01, Imm16=0xFFFE, LineSelection=1 -> PC=0xFC. Same with LineSelection=0 -> PC=0x104.
- PC=0x1000_0010, PCSource=10, JumpAddr=0x0000040 -> PC=0x1000_0100.
- PC=0x200, PCSource=11, RegA=0x302 -> Trap=1, PC=0x200, EPC=0x200, BadAddr=0x302. Further PCWrite strobes leave PC unchanged. Resume -> PC=0x80, Trap=0.
- In TRAP, assert reset -> PC=RESET_PC, Trap=0, EPC=0, BadAddr=0. PC=0xFFFF_FFFC with PCSource=00 -> PC wraps to 0.
- With BRANCH_STATS_EN: 5 branches, 3 taken -> BranchCount=5, TakenCount=3. Counter preloaded to 0xFFFF via 65535 branches plus one more -> stays 0xFFFF. Without BRANCH_STATS_EN: both outputs stay 0.
